// File: rtl/tinyqv_exec_sequencer_pkg.sv
// Shared definitions for the tinyqv execution sequencer: FSM states, pass length
// and the nibble selector used by every serial data path.
package tinyqv_exec_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXEC     = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_MEM_PASS = 2'd3
  } seq_state_e;

  localparam logic [2:0] SEQ_PASS_LAST = 3'd7;

  function automatic logic [3:0] nibble_at(input logic [31:0] word, input logic [2:0] idx);
    return word[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/tinyqv_exec_sequencer_if.sv
// Single-outstanding data-memory bus between the sequencer (master) and memory (slave).
interface tinyqv_exec_sequencer_if #(
  parameter int ADDR_BITS = 28
) ();

  logic                 mem_req;
  logic                 mem_write;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [31:0]          mem_wdata;
  logic                 mem_ready;
  logic [31:0]          mem_rdata;

  modport master (
    output mem_req, mem_write, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_write, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/tinyqv_exec_sequencer_nibble_reg.sv
// 32-bit register written either one nibble at a time (serial store data) or
// as a whole word (load data returned by memory).
module tinyqv_nibble_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nib_we_i,
  input  logic [2:0]  nib_idx_i,
  input  logic [3:0]  nib_data_i,
  input  logic        word_we_i,
  input  logic [31:0] word_data_i,
  output logic [31:0] word_o
);

  logic [31:0] word_q;

  // NOTE: reset to zero because the value is visible on the core's nibble inputs straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
    end else if (word_we_i) begin
      word_q <= word_data_i;
    end else if (nib_we_i) begin
      word_q[{nib_idx_i, 2'b00} +: 4] <= nib_data_i;
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/tinyqv_exec_sequencer.sv
// Sequencer for the nibble-serial tinyqv core: owns the PC, runs 8-cycle nibble
// passes and performs the single data-memory transaction for loads and stores.
module tinyqv_exec_sequencer
  import tinyqv_exec_sequencer_pkg::*;
#(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter int          ADDR_BITS = 28
) (
  input  logic                 clk,
  input  logic                 rstn,

  input  logic                 instr_valid,
  input  logic [1:0]           instr_len,
  output logic                 instr_ack,
  output logic                 flush,
  output logic [31:0]          pc,

  output logic [2:0]           core_counter,
  output logic [3:0]           core_pc_nibble,
  output logic [3:0]           core_next_pc_nibble,
  output logic [3:0]           core_data_in_nibble,
  output logic                 core_load_data_ready,
  input  logic                 core_is_load,
  input  logic                 core_is_store,
  input  logic [3:0]           core_data_out_nibble,
  input  logic [ADDR_BITS-1:0] core_addr,
  input  logic                 core_address_ready,
  input  logic                 core_instr_complete,
  input  logic                 core_branch,

  tinyqv_exec_sequencer_if.master mem
);

  seq_state_e           state_q;
  logic [2:0]           counter_q;
  logic [31:0]          pc_q;
  logic                 ack_q;
  logic                 flush_q;
  logic                 load_data_ready_q;
  logic                 mem_req_q;
  logic                 mem_write_q;
  logic [ADDR_BITS-1:0] mem_addr_q;
  logic [31:0]          mem_wdata_q;

  logic [31:0] next_pc_d;
  logic [31:0] wdata_word;
  logic [31:0] rdata_word;
  logic [31:0] store_word;
  logic        in_pass;
  logic        pass_last;
  logic        start_mem;
  logic        retire;
  logic        capture_rdata;

  assign in_pass       = (state_q == ST_EXEC) || (state_q == ST_MEM_PASS);
  assign pass_last     = (counter_q == SEQ_PASS_LAST);
  assign start_mem     = (state_q == ST_EXEC) && pass_last && core_address_ready &&
                         (core_is_load || core_is_store);
  // A memory request outranks a completion flagged in the same cycle.
  assign retire        = in_pass && pass_last && core_instr_complete && !start_mem;
  assign capture_rdata = (state_q == ST_MEM_WAIT) && mem.mem_ready && !mem_write_q;

  assign next_pc_d  = pc_q + {29'd0, instr_len, 1'b0};
  // The last nibble arrives in the same cycle the request is launched.
  assign store_word = {core_data_out_nibble, wdata_word[27:0]};

  tinyqv_nibble_reg u_wdata (
    .clk         (clk),
    .rst_n       (rstn),
    .nib_we_i    (in_pass),
    .nib_idx_i   (counter_q),
    .nib_data_i  (core_data_out_nibble),
    .word_we_i   (1'b0),
    .word_data_i (32'd0),
    .word_o      (wdata_word)
  );

  tinyqv_nibble_reg u_rdata (
    .clk         (clk),
    .rst_n       (rstn),
    .nib_we_i    (1'b0),
    .nib_idx_i   (3'd0),
    .nib_data_i  (4'd0),
    .word_we_i   (capture_rdata),
    .word_data_i (mem.mem_rdata),
    .word_o      (rdata_word)
  );

  // NOTE: non-blocking assignments throughout so every branch reads pre-edge state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q           <= ST_IDLE;
      counter_q         <= 3'd0;
      pc_q              <= PC_RESET;
      ack_q             <= 1'b0;
      flush_q           <= 1'b0;
      load_data_ready_q <= 1'b0;
      mem_req_q         <= 1'b0;
      mem_write_q       <= 1'b0;
      mem_addr_q        <= '0;
      mem_wdata_q       <= '0;
    end else begin
      ack_q   <= 1'b0;
      flush_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          counter_q <= 3'd0;
          if (instr_valid) state_q <= ST_EXEC;
        end
        ST_EXEC, ST_MEM_PASS: begin
          counter_q <= counter_q + 3'd1;
          if (start_mem) begin
            mem_addr_q  <= core_addr;
            mem_wdata_q <= store_word;
            mem_write_q <= core_is_store;
            mem_req_q   <= 1'b1;
            counter_q   <= 3'd0;
            state_q     <= ST_MEM_WAIT;
          end else if (retire) begin
            load_data_ready_q <= 1'b0;
            if (core_branch) begin
              pc_q    <= {pc_q[31:ADDR_BITS], core_addr};
              flush_q <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              pc_q    <= next_pc_d;
              ack_q   <= 1'b1;
              state_q <= instr_valid ? ST_EXEC : ST_IDLE;
            end
          end
          // Otherwise a multi-pass instruction simply wraps into another pass.
        end
        ST_MEM_WAIT: begin
          counter_q <= 3'd0;
          if (mem.mem_ready) begin
            mem_req_q         <= 1'b0;
            load_data_ready_q <= 1'b1;
            state_q           <= ST_MEM_PASS;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign instr_ack            = ack_q;
  assign flush                = flush_q;
  assign pc                   = pc_q;
  assign core_counter         = counter_q;
  assign core_pc_nibble       = nibble_at(pc_q, counter_q);
  assign core_next_pc_nibble  = nibble_at(next_pc_d, counter_q);
  assign core_data_in_nibble  = nibble_at(rdata_word, counter_q);
  assign core_load_data_ready = load_data_ready_q;

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_write = mem_write_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

  // The core may only present completion or an address on the last nibble of a pass.
  a_core_strobe_at_last: assert property (@(posedge clk) disable iff (!rstn)
    (core_instr_complete || core_address_ready) |-> (in_pass && pass_last));

  a_retire_exclusive: assert property (@(posedge clk) disable iff (!rstn)
    !(ack_q && flush_q));

endmodule

// File: tb/tb_tinyqv_exec_sequencer.sv
// Randomised scoreboard bench for tinyqv_exec_sequencer: a cycle-level core/memory
// driver predicts retirements and memory requests, a monitor checks them.
module tb_tinyqv_exec_sequencer;

  localparam logic [31:0] PC_RST = 32'hF000_0100;
  localparam int          AB     = 28;
  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        instr_valid = 1'b0;
  logic [1:0]  instr_len = 2'd0;
  logic        instr_ack, flush;
  logic [31:0] pc;
  logic [2:0]  core_counter;
  logic [3:0]  core_pc_nibble, core_next_pc_nibble, core_data_in_nibble;
  logic        core_load_data_ready;
  logic        core_is_load = 1'b0, core_is_store = 1'b0;
  logic [3:0]  core_data_out_nibble = 4'd0;
  logic [AB-1:0] core_addr = '0;
  logic        core_address_ready = 1'b0, core_instr_complete = 1'b0, core_branch = 1'b0;

  tinyqv_exec_sequencer_if #(.ADDR_BITS(AB)) mem_if ();

  tinyqv_exec_sequencer #(.PC_RESET(PC_RST), .ADDR_BITS(AB)) u_dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .instr_valid          (instr_valid),
    .instr_len            (instr_len),
    .instr_ack            (instr_ack),
    .flush                (flush),
    .pc                   (pc),
    .core_counter         (core_counter),
    .core_pc_nibble       (core_pc_nibble),
    .core_next_pc_nibble  (core_next_pc_nibble),
    .core_data_in_nibble  (core_data_in_nibble),
    .core_load_data_ready (core_load_data_ready),
    .core_is_load         (core_is_load),
    .core_is_store        (core_is_store),
    .core_data_out_nibble (core_data_out_nibble),
    .core_addr            (core_addr),
    .core_address_ready   (core_address_ready),
    .core_instr_complete  (core_instr_complete),
    .core_branch          (core_branch),
    .mem                  (mem_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { bit br; logic [31:0] pc; int at; } ret_t;
  typedef struct { bit wr; logic [27:0] addr; logic [31:0] wdata; int at; } memx_t;
  ret_t  ret_q[$];
  memx_t mem_q[$];

  logic [31:0] model_pc = PC_RST;
  bit          seq_idle = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    core_address_ready  = 1'b0;
    core_instr_complete = 1'b0;
    core_branch         = 1'b0;
  endtask

  // Reference rules for retirement: branch keeps the PC top bits, else PC += 2*len.
  task automatic do_retire(input int kind, input logic [1:0] len, input logic [27:0] addr, input bit keep);
    if (kind == K_BR) begin
      model_pc = {model_pc[31:28], addr};
      seq_idle = 1'b1;
      ret_q.push_back('{1'b1, model_pc, cyc + 1});
    end else begin
      model_pc = model_pc + 32'(2 * int'(len));
      seq_idle = !keep;
      ret_q.push_back('{1'b0, model_pc, cyc + 1});
    end
  endtask

  task automatic idle(input int n);
    instr_valid = 1'b0;
    clear_strobes();
    repeat (n) begin
      #1;
      check("idle_counter", 64'(core_counter), 64'd0);
      step();
    end
  endtask

  task automatic run_instr(input int kind, input logic [1:0] len, input int npass,
                           input logic [27:0] addr, input logic [31:0] sdata,
                           input logic [31:0] rdat, input int wt, input bit keep,
                           input bit abort);
    logic [31:0] cur_pc, npc;
    bit is_mem;
    is_mem        = (kind == K_LOAD) || (kind == K_STORE);
    instr_valid   = 1'b1;
    instr_len     = len;
    core_is_load  = (kind == K_LOAD);
    core_is_store = (kind == K_STORE);
    clear_strobes();
    if (seq_idle) begin
      #1;
      check("start_counter", 64'(core_counter), 64'd0);
      step();
    end
    cur_pc = model_pc;
    npc    = model_pc + 32'(2 * int'(len));
    for (int p = 0; p < npass; p++) begin
      for (int c = 0; c < 8; c++) begin
        core_data_out_nibble = (p == npass - 1) ? sdata[4*c +: 4] : 4'($urandom);
        core_addr = 28'($urandom);
        clear_strobes();
        if (p == npass - 1 && c == 7) begin
          core_addr = addr;
          if (is_mem) begin
            core_address_ready  = 1'b1;
            core_instr_complete = 1'($urandom_range(0, 1));
            mem_q.push_back('{kind == K_STORE, addr, sdata, cyc + 1});
          end else begin
            core_instr_complete = 1'b1;
            core_branch         = (kind == K_BR);
            instr_valid         = keep;
            do_retire(kind, len, addr, keep);
          end
        end
        #1;
        check("exec_counter", 64'(core_counter), 64'(c));
        check("pc_nibble", 64'(core_pc_nibble), 64'(4'(cur_pc >> (4 * c))));
        check("next_pc_nibble", 64'(core_next_pc_nibble), 64'(4'(npc >> (4 * c))));
        check("exec_ldr", 64'(core_load_data_ready), 64'd0);
        step();
      end
    end
    clear_strobes();
    if (is_mem) begin
      for (int w = 0; w <= wt; w++) begin
        mem_if.mem_ready = (w == wt);
        mem_if.mem_rdata = (w == wt) ? rdat : $urandom;
        if (abort && w == 1) begin
          rstn = 1'b0;
          mem_if.mem_ready = 1'b0;
          instr_valid = 1'b0;
          #1;
          check("rst_mem_req", 64'(mem_if.mem_req), 64'd0);
          check("rst_pc", 64'(pc), 64'(PC_RST));
          check("rst_counter", 64'(core_counter), 64'd0);
          check("rst_ldr", 64'(core_load_data_ready), 64'd0);
          model_pc = PC_RST;
          seq_idle = 1'b1;
          step();
          step();
          rstn = 1'b1;
          step();
          idle(3);
          return;
        end
        #1;
        check("wait_counter", 64'(core_counter), 64'd0);
        step();
      end
      mem_if.mem_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
        core_data_out_nibble = 4'($urandom);
        core_addr = 28'($urandom);
        clear_strobes();
        if (c == 7) begin
          core_instr_complete = 1'b1;
          instr_valid         = keep;
          do_retire(kind, len, addr, keep);
        end
        #1;
        check("mpass_counter", 64'(core_counter), 64'(c));
        check("mpass_ldr", 64'(core_load_data_ready), 64'd1);
        if (kind == K_LOAD)
          check("load_nibble", 64'(core_data_in_nibble), 64'(4'(rdat >> (4 * c))));
        step();
      end
      clear_strobes();
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT launches a request or retires.
  initial begin : monitor
    bit    seen;
    memx_t cur;
    ret_t  r;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      if (!rstn) begin
        seen = 1'b0;
        continue;
      end
      if (mem_if.mem_req) begin
        if (!seen) begin
          if (mem_q.size() == 0) begin
            check("mem_req_unexpected", 64'd1, 64'd0);
            cur = '{1'b0, 28'd0, 32'd0, 0};
          end else begin
            cur = mem_q.pop_front();
            check("mem_write", 64'(mem_if.mem_write), 64'(cur.wr));
            check("mem_addr", 64'(mem_if.mem_addr), 64'(cur.addr));
            check("mem_wdata", 64'(mem_if.mem_wdata), 64'(cur.wdata));
            check("mem_req_cycle", 64'(cyc), 64'(cur.at));
          end
          seen = 1'b1;
        end else begin
          check("mem_hold", {3'd0, mem_if.mem_write, mem_if.mem_addr, mem_if.mem_wdata},
                {3'd0, cur.wr, cur.addr, cur.wdata});
        end
      end else begin
        seen = 1'b0;
      end
      if (instr_ack || flush) begin
        if (ret_q.size() == 0) begin
          check("retire_unexpected", 64'({instr_ack, flush}), 64'd0);
        end else begin
          r = ret_q.pop_front();
          check("flush", 64'(flush), 64'(r.br));
          check("instr_ack", 64'(instr_ack), 64'(!r.br));
          check("retire_pc", 64'(pc), 64'(r.pc));
          check("retire_cycle", 64'(cyc), 64'(r.at));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int kind, np, wt;
    logic [1:0]  len;
    logic [27:0] addr;
    logic [31:0] sd, rd;
    bit keep;
    mem_if.mem_ready = 1'b0;
    mem_if.mem_rdata = 32'd0;

    repeat (2) @(negedge clk);
    #1;
    check("reset_pc", 64'(pc), 64'(PC_RST));
    check("reset_counter", 64'(core_counter), 64'd0);
    check("reset_ack_flush", 64'({instr_ack, flush}), 64'd0);
    check("reset_mem_req_write", 64'({mem_if.mem_req, mem_if.mem_write}), 64'd0);
    check("reset_mem_addr", 64'(mem_if.mem_addr), 64'd0);
    check("reset_mem_wdata", 64'(mem_if.mem_wdata), 64'd0);
    check("reset_ldr_rdata", 64'({core_load_data_ready, core_data_in_nibble}), 64'd0);
    rstn = 1'b1;
    step();

    // Directed: ALU pair, load, store, two branches, compressed wrap to zero.
    run_instr(K_ALU, 2'd2, 1, 28'd0, $urandom, 32'd0, 0, 1'b1, 1'b0);
    run_instr(K_ALU, 2'd2, 1, 28'd0, $urandom, 32'd0, 0, 1'b0, 1'b0);
    check("alu_pair_pc", 64'(pc), 64'(32'hF000_0108));
    run_instr(K_LOAD, 2'd2, 1, 28'h0000010, $urandom, 32'hDEAD_BEEF, 3, 1'b1, 1'b0);
    run_instr(K_STORE, 2'd2, 1, 28'h0000040, 32'h8765_4321, 32'd0, 0, 1'b1, 1'b0);
    run_instr(K_BR, 2'd2, 1, 28'h0000200, $urandom, 32'd0, 0, 1'b1, 1'b0);
    check("branch_pc", 64'(pc), 64'(32'hF000_0200));
    idle(2);
    run_instr(K_BR, 2'd2, 2, 28'hFFF_FFFE, $urandom, 32'd0, 0, 1'b1, 1'b0);
    run_instr(K_ALU, 2'd1, 1, 28'd0, $urandom, 32'd0, 0, 1'b0, 1'b0);
    check("wrap_pc", 64'(pc), 64'd0);

    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 3);
      len  = 2'($urandom_range(1, 3));
      np   = $urandom_range(1, 2);
      addr = 28'($urandom);
      sd   = $urandom;
      rd   = $urandom;
      wt   = $urandom_range(0, 3);
      keep = ($urandom_range(0, 3) != 0);
      if (seq_idle && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      run_instr(kind, len, np, addr, sd, rd, wt, keep, 1'b0);
    end

    // Reset while a load waits for memory, then confirm normal restart.
    if (!seq_idle) run_instr(K_ALU, 2'd2, 1, 28'd0, $urandom, 32'd0, 0, 1'b0, 1'b0);
    run_instr(K_LOAD, 2'd2, 1, 28'h0000055, $urandom, $urandom, 3, 1'b0, 1'b1);
    run_instr(K_ALU, 2'd2, 1, 28'd0, $urandom, 32'd0, 0, 1'b0, 1'b0);
    check("post_reset_pc", 64'(pc), 64'(PC_RST + 32'd4));

    idle(3);
    check("ret_q_drained", 64'(ret_q.size()), 64'd0);
    check("mem_q_drained", 64'(mem_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
